// File: rtl/logicnet_input_packer_if.sv
// Handshake bundle between the feature stream source, the input packer and layer 0.
// The slave modport is the packer's view of the bundle; the master modport is the source/sink side.
interface logicnet_input_packer_if #(
  parameter int unsigned FEAT_W = 16,
  parameter int unsigned QBITS  = 2,
  parameter int unsigned N_FEAT = 64
);
  logic                      s_valid;
  logic                      s_ready;
  logic [FEAT_W-1:0]         s_data;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [N_FEAT*QBITS-1:0]   m_data;
  logic                      err;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, err
  );
endinterface

// File: rtl/logicnet_input_packer.sv
// Quantizes a serial feature stream into QBITS codes and packs N_FEAT of them per output vector.
// Optional s_last framing check and sticky err flag: LOGICNET_PACKER_LAST_CHECK_EN.
module logicnet_input_packer #(
  parameter int unsigned FEAT_W = 16,
  parameter int unsigned QBITS  = 2,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned N_FEAT = 64
) (
  input logic                    clk,
  input logic                    rst,
  logicnet_input_packer_if.slave bus
);
  localparam int unsigned VEC_W = N_FEAT * QBITS;
  localparam int unsigned CNT_W = $clog2(N_FEAT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);
  localparam int QMAX_I = (2 ** (QBITS - 1)) - 1;
  localparam int QMIN_I = -(2 ** (QBITS - 1));
  localparam logic signed [FEAT_W-1:0] QMAX = FEAT_W'(QMAX_I);
  localparam logic signed [FEAT_W-1:0] QMIN = FEAT_W'(QMIN_I);

  typedef enum logic [0:0] {StFill, StPend} state_e;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [VEC_W-1:0]    r_fill;
  logic [VEC_W-1:0]    r_out;
  logic                r_valid;

  logic signed [FEAT_W-1:0] w_shift;
  logic signed [FEAT_W-1:0] w_sat;
  logic [QBITS-1:0]         w_code;
  logic [VEC_W-1:0]         w_fill_next;
  logic                     w_accept;
  logic                     w_last_slot;
  logic                     w_complete;
  logic                     w_out_free;
  logic                     w_abort;

  assign w_shift = $signed(bus.s_data) >>> SHIFT;

  always_comb begin
    if (w_shift > QMAX) begin
      w_sat = QMAX;
    end else if (w_shift < QMIN) begin
      w_sat = QMIN;
    end else begin
      w_sat = w_shift;
    end
  end

  assign w_code = w_sat[QBITS-1:0];

  // Fill vector as it will look once the current beat lands, so a completing
  // frame can be forwarded to the output register on the same edge.
  always_comb begin
    w_fill_next = r_fill;
    w_fill_next[int'(r_cnt) * QBITS +: QBITS] = w_code;
  end

  // Registered state only; rst gating keeps the source stalled during reset.
  assign bus.s_ready = (r_state == StFill) && !rst;
  assign w_accept    = bus.s_valid && bus.s_ready;
  assign w_last_slot = (r_cnt == LAST_IDX);
  assign w_complete  = w_accept && w_last_slot;
  assign w_out_free  = !r_valid || bus.m_ready;

`ifdef LOGICNET_PACKER_LAST_CHECK_EN
  logic r_err;
  logic w_missing_last;

  assign w_abort        = w_accept && bus.s_last && !w_last_slot;
  assign w_missing_last = w_accept && w_last_slot && !bus.s_last;
  assign bus.err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_abort || w_missing_last) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_last;

  assign w_abort       = 1'b0;
  assign w_unused_last = bus.s_last;
  assign bus.err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFill;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fill <= w_fill_next;
        r_cnt  <= (w_last_slot || w_abort) ? '0 : r_cnt + 1'b1;
      end
      case (r_state)
        StFill: begin
          if (w_complete && w_out_free) begin
            r_out   <= w_fill_next;
            r_valid <= 1'b1;
          end else if (w_complete) begin
            r_state <= StPend;
          end else if (r_valid && bus.m_ready) begin
            r_valid <= 1'b0;
          end
        end
        StPend: begin
          // Output is always occupied here; a handshake swaps in the held frame.
          if (bus.m_ready) begin
            r_out   <= r_fill;
            r_state <= StFill;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign bus.m_valid = r_valid;
  assign bus.m_data  = r_out;
endmodule

// File: doc/logicnet_input_packer.md
# logicnet_input_packer

Front end of the LogicNets inference pipeline, directly upstream of layer 0. Accepts a serial stream of signed fixed-point features over a valid/ready handshake and quantizes each one to a QBITS two's-complement code. Packs N_FEAT codes into the flat input vector consumed by the layer-0 neuron LUTs, and presents that vector with its own valid/ready handshake. Storage is a fill register plus an output register, so collection of the next frame overlaps with the hold of the current one.

## Interface

Parameters:
- FEAT_W, 16: width of the signed input feature.
- QBITS, 2: bits per quantized code; must be ≥2.
- SHIFT, 8: arithmetic right shift applied before saturation; must be < FEAT_W.
- N_FEAT, 64: features per frame; must be ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  packer can accept a beat.
- s_data  in  FEAT_W  signed feature.
- s_last  in  1  final feature of the frame.
- m_valid  out  1  packed vector valid.
- m_ready  in  1  layer 0 accepts the vector.
- m_data  out  N_FEAT*QBITS  packed codes; feature k is at [k*QBITS +: QBITS].
- err  out  1  sticky framing error.

## Operation

- **Quantize:** y = s_data >>> SHIFT, then saturate to [-2^(QBITS-1), 2^(QBITS-1)-1]. The code is the low QBITS bits of y in two's complement. This path is combinational; the result is stored on acceptance.
- **Accept:** a beat is accepted when s_valid && s_ready. The code is written to fill slot cnt, and cnt increments, wrapping to 0 after N_FEAT-1.
- **States:**
  - FILL: s_ready=1.
  - PEND: the fill register is complete but the output register is occupied; s_ready=0.
- **Completion of a frame** (beat accepted with cnt==N_FEAT-1):
  - If the output register is free (!m_valid, or m_valid && m_ready in the same cycle): at that edge, m_data loads the completed vector, including the final code, and m_valid=1. The state stays FILL.
  - Otherwise: go to PEND.
- **PEND exit:** on the edge with m_valid && m_ready, m_data loads the fill vector, m_valid stays 1, and the state goes to FILL.
- **Output hold:** m_valid deasserts only on a handshake with no new vector loading. m_data is stable while m_valid && !m_ready.
- **Unused fill slots** hold stale data. Every slot is overwritten before its next transfer.

## Timing

- **Reset values:** m_valid=0, m_data=0, err=0, cnt=0, state FILL. s_ready=0 while rst is high and 1 in the first cycle after release.
- **Latency:** m_valid rises in the cycle after the final beat is accepted (one cycle).
- **Throughput:** one frame per N_FEAT cycles with no bubbles when m_ready is held high.
- **Final beat with simultaneous output handshake:** the new vector replaces the old one at the same edge, and m_valid stays 1.
- **Reset mid-frame:** the partial frame and any held vector are discarded, and the first beat after reset goes to slot 0.
- **s_ready** depends only on registered state, never on m_ready.

## Configuration

Macro LOGICNET_PACKER_LAST_CHECK_EN.

Defined:
- s_last asserted on an accepted beat with cnt≠N_FEAT-1: set err, discard the partial frame (cnt←0), and do not emit that frame.
- s_last low on the beat with cnt==N_FEAT-1: set err, but emit the frame normally.
- err clears only on rst.

Undefined:
- s_last is ignored.
- err is tied to 0.
- Framing is purely by count.

## Test plan

Defaults apply unless stated (FEAT_W=16, QBITS=2, SHIFT=8, N_FEAT=64).

1. **Quantize:** feed beats 0x0180, 0x7FFF, 0xFFFF, 0x8000, 0x0000, then 59 zeros, with m_ready=1. Required: m_data[9:0]=10'b00_10_11_01_01, m_valid for exactly one cycle, one cycle after the last beat.
2. **Back-pressure:** with m_ready=0, stream two full frames. Required: s_ready=0 after the 128th beat (PEND). Set m_ready=1 for one cycle: frame 1 leaves, frame 2 appears next cycle with m_valid still 1, and s_ready returns to 1.
3. **Streaming:** run 4 back-to-back frames with s_valid=1 and m_ready=1. Required: m_valid pulses every 64 cycles and s_ready never drops.
4. **Reset mid-frame:** after 30 beats assert rst for one cycle, then send 64 beats. Required: exactly one vector, containing only post-reset data, and err=0.
5. **Early s_last** (macro defined): assert s_last on beat 10, then send a full 64-beat frame with s_last on beat 63. Required: err=1 from the cycle after beat 10, and exactly one vector emitted, equal to the second frame.
6. **Early s_last** (macro undefined): same stimulus as scenario 5. Required: err stays 0, and the first vector is emitted after 64 total beats, ignoring s_last.
